// File: rtl/player_draw_ctrl.sv
// ---------------------------------------------------------------------------
// player_draw_ctrl
//
// Frame-rate sequencer for the player ship. Each accepted frame tick runs
// the sequence IDLE -> ERASE (8 px) -> MOVE (1) -> SETTLE (2) -> DRAW (8)
// -> IDLE. ERASE paints the 2x4 sprite in the background colour, MOVE
// issues at most one single-step vertical move pulse, SETTLE waits out the
// position stage's latency and DRAW repaints the sprite at the new y.
// A shadow copy of y keeps the ship inside rows 0..Y_MAX.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high; returns to IDLE, clears state
//   frame_tick : one-cycle pulse at frame rate
//   key_up     : level, request y-1 (already synchronised)
//   key_down   : level, request y+1 (already synchronised)
//   add_x      : sprite column offset (pix_cnt[0])
//   add_y      : sprite row offset (pix_cnt[2:1])
//   y_pos_mod  : one-cycle pulse, y+1 in the position stage
//   y_neg_mod  : one-cycle pulse, y-1 in the position stage
//   colour     : pixel colour, valid while plot=1
//   plot       : VGA adapter write enable
//   busy       : high in every state except IDLE
//   overrun    : one-cycle pulse when frame_tick arrives while busy
// ---------------------------------------------------------------------------
module player_draw_ctrl #(
  parameter logic [2:0] SHIP_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR   = 3'b000,
  parameter logic [6:0] Y_MAX       = 7'd124,
  parameter int         MOVE_DIV    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       key_up,
  input  logic       key_down,
  output logic       add_x,
  output logic [1:0] add_y,
  output logic       y_pos_mod,
  output logic       y_neg_mod,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ERASE  = 3'd1,
    MOVE   = 3'd2,
    SETTLE = 3'd3,
    DRAW   = 3'd4
  } state_t;

  localparam logic [3:0] DIV_LAST = 4'(MOVE_DIV - 1);

  state_t     state_q, state_d;
  logic [2:0] pix_cnt_q, pix_cnt_d;
  logic [6:0] y_shadow_q, y_shadow_d;
  logic [3:0] div_cnt_q, div_cnt_d;

  logic       add_x_d;
  logic [1:0] add_y_d;
  logic       y_pos_mod_d, y_neg_mod_d;
  logic [2:0] colour_d;
  logic       plot_d, busy_d, overrun_d;

  // Next-state logic. Outputs are derived from the next state so that the
  // registered outputs line up with the state they describe; this is why
  // the move decision is taken on the ERASE->MOVE transition, so the pulse
  // is high exactly during the MOVE cycle. SETTLE reuses pix_cnt to count
  // its two cycles.
  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    y_shadow_d  = y_shadow_q;
    div_cnt_d   = div_cnt_q;
    y_pos_mod_d = 1'b0;
    y_neg_mod_d = 1'b0;
    overrun_d   = frame_tick && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d   = ERASE;
          pix_cnt_d = 3'd0;
        end
      end
      ERASE: begin
        if (pix_cnt_q == 3'd7) begin
          state_d   = MOVE;
          pix_cnt_d = 3'd0;
          // Only one of the two pulses can fire: each branch requires the
          // other key to be released.
          if (div_cnt_q == 4'd0) begin
            if (key_down && !key_up && (y_shadow_q < Y_MAX)) begin
              y_pos_mod_d = 1'b1;
              y_shadow_d  = y_shadow_q + 7'd1;
            end else if (key_up && !key_down && (y_shadow_q != 7'd0)) begin
              y_neg_mod_d = 1'b1;
              y_shadow_d  = y_shadow_q - 7'd1;
            end
          end
          div_cnt_d = (div_cnt_q == DIV_LAST) ? 4'd0 : div_cnt_q + 4'd1;
        end else begin
          pix_cnt_d = pix_cnt_q + 3'd1;
        end
      end
      MOVE: begin
        state_d   = SETTLE;
        pix_cnt_d = 3'd0;
      end
      SETTLE: begin
        if (pix_cnt_q == 3'd1) begin
          state_d   = DRAW;
          pix_cnt_d = 3'd0;
        end else begin
          pix_cnt_d = pix_cnt_q + 3'd1;
        end
      end
      DRAW: begin
        if (pix_cnt_q == 3'd7) begin
          state_d   = IDLE;
          pix_cnt_d = 3'd0;
        end else begin
          pix_cnt_d = pix_cnt_q + 3'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        pix_cnt_d = 3'd0;
      end
    endcase

    plot_d   = (state_d == ERASE) || (state_d == DRAW);
    busy_d   = (state_d != IDLE);
    colour_d = (state_d == DRAW)  ? SHIP_COLOUR :
               (state_d == ERASE) ? BG_COLOUR   : 3'b000;
    add_x_d  = pix_cnt_d[0];
    add_y_d  = pix_cnt_d[2:1];
  end

  // State and output registers; reset aborts any sequence in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pix_cnt_q  <= 3'd0;
      y_shadow_q <= 7'd0;
      div_cnt_q  <= 4'd0;
      add_x      <= 1'b0;
      add_y      <= 2'd0;
      y_pos_mod  <= 1'b0;
      y_neg_mod  <= 1'b0;
      colour     <= 3'd0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      y_shadow_q <= y_shadow_d;
      div_cnt_q  <= div_cnt_d;
      add_x      <= add_x_d;
      add_y      <= add_y_d;
      y_pos_mod  <= y_pos_mod_d;
      y_neg_mod  <= y_neg_mod_d;
      colour     <= colour_d;
      plot       <= plot_d;
      busy       <= busy_d;
      overrun    <= overrun_d;
    end
  end

endmodule
